// File: rtl/sreg_pkg.sv
// sreg_pkg: shared definitions for the sreg_xfer shift engine.
//   state_e   - engine state encoding (StIdle = 0, StShift = 1)
//   clog2     - ceiling log2 for constant sizing
//   cnt_width - beat counter width, never narrower than one bit
package sreg_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned beats);
        int unsigned w;
        w = clog2(beats);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sreg_beat_cnt.sv
// sreg_beat_cnt: beat counter for the shift engine.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   clr   in  synchronous clear to zero (priority over en)
//   en    in  count one beat
//   tc    out terminal count: counter currently equals BEATS-1
module sreg_beat_cnt #(
    parameter int unsigned BEATS = 16,
    parameter int unsigned CNT_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            // Wraps (or overshoots) after the final beat; the next load clears it.
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tc = (cnt_q == CNT_W'(BEATS - 1));

endmodule

// File: rtl/sreg_xfer.sv
// sreg_xfer: serialises a parallel word onto LANES serial lanes while capturing
// the same number of bits back into a parallel word.
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   pin        in  parallel word to transmit
//   load_valid in  pin valid; accepted when load_valid & load_ready
//   load_ready out engine idle and able to accept a word
//   sft_en     in  single-cycle beat strobe
//   abort      in  synchronous cancel of the transfer in progress
//   sin        in  serial input lanes, sampled on each beat
//   sout       out serial output lanes, active end of the shift register
//   pout       out last completed received word
//   done       out one-cycle completion pulse
//   busy       out transfer in progress
module sreg_xfer
    import sreg_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned LANES     = 1,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pin,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             sft_en,
    input  logic             abort,
    input  logic [LANES-1:0] sin,
    output logic [LANES-1:0] sout,
    output logic [WIDTH-1:0] pout,
    output logic             done,
    output logic             busy
);

    localparam int unsigned BEATS = WIDTH / LANES;
    localparam int unsigned CNT_W = cnt_width(BEATS);

    if ((LANES == 0) || (WIDTH < LANES) || ((WIDTH % LANES) != 0)) begin : g_bad_params
        $error("sreg_xfer: WIDTH must be a non-zero multiple of LANES");
    end

    state_e           state_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_shift;
    logic [WIDTH-1:0] pout_q;
    logic             done_q;
    logic             accept;
    logic             beat;
    logic             tc;

    // Shift direction and the degenerate one-beat case are fixed at elaboration.
    if (LANES == WIDTH) begin : g_shift_full
        assign sr_shift = sin;
        assign sout     = sr_q;
    end else if (MSB_FIRST) begin : g_shift_left
        assign sr_shift = {sr_q[WIDTH-LANES-1:0], sin};
        assign sout     = sr_q[WIDTH-1 -: LANES];
    end else begin : g_shift_right
        assign sr_shift = {sin, sr_q[WIDTH-1:LANES]};
        assign sout     = sr_q[LANES-1:0];
    end

    // Held off during the done cycle so a new load always sees one idle cycle
    // after completion; both terms are registers.
    assign load_ready = (state_q == StIdle) && !done_q;
    assign busy       = (state_q == StShift);
    assign accept     = load_valid && load_ready;
    // abort outranks sft_en: an aborted cycle neither shifts nor counts.
    assign beat       = (state_q == StShift) && sft_en && !abort;

    sreg_beat_cnt #(
        .BEATS (BEATS),
        .CNT_W (CNT_W)
    ) u_beat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (beat),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sr_q    <= '0;
            pout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        sr_q    <= pin;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (abort) begin
                        // sr and the beat count are left as they were.
                        state_q <= StIdle;
                    end else if (sft_en) begin
                        sr_q <= sr_shift;
                        if (tc) begin
                            pout_q  <= sr_shift;
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                end
            endcase
        end
    end

    assign pout = pout_q;
    assign done = done_q;

endmodule

// File: tb/tb_sreg_xfer.sv
// tb_sreg_xfer: directed self-checking bench for sreg_xfer.
// Three instances: 16x1 MSB-first, 16x4 MSB-first, 8x2 LSB-first.
module tb_sreg_xfer;

    logic        clk;
    logic        rst_n;
    logic [15:0] pin [3];
    logic        lv  [3];
    logic        sft [3];
    logic        ab  [3];
    logic [3:0]  sin [3];

    logic [0:0]  sout0;
    logic [3:0]  sout1;
    logic [1:0]  sout2;
    logic [15:0] pout0;
    logic [15:0] pout1;
    logic [7:0]  pout2;
    logic        done_w  [3];
    logic        busy_w  [3];
    logic        ready_w [3];

    int n_checks;
    int n_fail;

    sreg_xfer #(.WIDTH(16), .LANES(1), .MSB_FIRST(1'b1)) u_dut_1l (
        .clk        (clk),
        .rst_n      (rst_n),
        .pin        (pin[0]),
        .load_valid (lv[0]),
        .load_ready (ready_w[0]),
        .sft_en     (sft[0]),
        .abort      (ab[0]),
        .sin        (sin[0][0:0]),
        .sout       (sout0),
        .pout       (pout0),
        .done       (done_w[0]),
        .busy       (busy_w[0])
    );

    sreg_xfer #(.WIDTH(16), .LANES(4), .MSB_FIRST(1'b1)) u_dut_4l (
        .clk        (clk),
        .rst_n      (rst_n),
        .pin        (pin[1]),
        .load_valid (lv[1]),
        .load_ready (ready_w[1]),
        .sft_en     (sft[1]),
        .abort      (ab[1]),
        .sin        (sin[1]),
        .sout       (sout1),
        .pout       (pout1),
        .done       (done_w[1]),
        .busy       (busy_w[1])
    );

    sreg_xfer #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .pin        (pin[2][7:0]),
        .load_valid (lv[2]),
        .load_ready (ready_w[2]),
        .sft_en     (sft[2]),
        .abort      (ab[2]),
        .sin        (sin[2][1:0]),
        .sout       (sout2),
        .pout       (pout2),
        .done       (done_w[2]),
        .busy       (busy_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] get_sout(input int d);
        case (d)
            0:       return {3'b0, sout0};
            1:       return sout1;
            default: return {2'b0, sout2};
        endcase
    endfunction

    function automatic logic [15:0] get_pout(input int d);
        case (d)
            0:       return pout0;
            1:       return pout1;
            default: return {8'b0, pout2};
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Full transfer on instance d; sin/sout groups are 4-bit slots, beat i at [i*4 +: 4].
    task automatic run_xfer(input int d, input logic [15:0] word, input int beats,
                            input logic [63:0] sin_bits, input logic [63:0] sout_bits,
                            input logic [15:0] exp_pout, input bit gaps);
        @(negedge clk);
        check_eq("ready_before_load", 32'(ready_w[d]), 32'd1);
        pin[d] = word;
        lv[d]  = 1'b1;
        @(negedge clk);
        lv[d] = 1'b0;
        check_eq("busy_after_load", 32'(busy_w[d]), 32'd1);
        check_eq("ready_after_load", 32'(ready_w[d]), 32'd0);
        for (int i = 0; i < beats; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            check_eq($sformatf("sout_beat%0d", i), 32'(get_sout(d)), 32'(sout_bits[i*4 +: 4]));
            sft[d] = 1'b1;
            sin[d] = sin_bits[i*4 +: 4];
            @(negedge clk);
            sft[d] = 1'b0;
            check_eq($sformatf("done_beat%0d", i), 32'(done_w[d]), 32'(i == beats - 1));
        end
        check_eq("busy_in_done", 32'(busy_w[d]), 32'd0);
        check_eq("ready_in_done", 32'(ready_w[d]), 32'd0);
        check_eq("pout", 32'(get_pout(d)), 32'(exp_pout));
        @(negedge clk);
        check_eq("done_single", 32'(done_w[d]), 32'd0);
        check_eq("ready_after_done", 32'(ready_w[d]), 32'd1);
    endtask

    initial begin
        logic [63:0] sin_bits;
        logic [63:0] sout_bits;
        logic [15:0] tx_word;
        logic [15:0] rx_word;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        for (int d = 0; d < 3; d++) begin
            pin[d] = '0;
            lv[d]  = 1'b0;
            sft[d] = 1'b0;
            ab[d]  = 1'b0;
            sin[d] = '0;
        end

        // Reset state of every instance.
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_eq("rst_sout", 32'(get_sout(d)), 32'd0);
            check_eq("rst_pout", 32'(get_pout(d)), 32'd0);
            check_eq("rst_done", 32'(done_w[d]), 32'd0);
            check_eq("rst_busy", 32'(busy_w[d]), 32'd0);
            check_eq("rst_ready", 32'(ready_w[d]), 32'd1);
        end
        rst_n = 1'b1;

        // Single lane, MSB first, random beat gaps.
        tx_word   = 16'hA5C3;
        rx_word   = 16'h1234;
        sin_bits  = '0;
        sout_bits = '0;
        for (int i = 0; i < 16; i++) begin
            sin_bits[i*4 +: 4]  = {3'b0, rx_word[15-i]};
            sout_bits[i*4 +: 4] = {3'b0, tx_word[15-i]};
        end
        run_xfer(0, tx_word, 16, sin_bits, sout_bits, 16'h1234, 1'b1);

        // Four lanes, MSB first: sout A,5,C,3; sin 1,2,3,4.
        run_xfer(1, 16'hA5C3, 4, {48'b0, 16'h4321}, {48'b0, 16'h3C5A}, 16'h1234, 1'b1);

        // Two lanes, LSB first: sout 0,1,3,2; sin 3,0,1,2.
        run_xfer(2, 16'h00B4, 4, {48'b0, 16'h2103}, {48'b0, 16'h2310}, 16'h0093, 1'b0);

        // sft_en while idle must leave sr (sout) and everything else alone.
        sft[2] = 1'b1;
        sin[2] = 4'h0;
        repeat (3) @(negedge clk);
        sft[2] = 1'b0;
        check_eq("idle_sft_sout", 32'(get_sout(2)), 32'd3);
        check_eq("idle_sft_busy", 32'(busy_w[2]), 32'd0);
        check_eq("idle_sft_done", 32'(done_w[2]), 32'd0);
        check_eq("idle_sft_pout", 32'(get_pout(2)), 32'h93);

        // load_valid and sft_en held high: 4 beats, done cycle, one ready cycle, repeat.
        @(negedge clk);
        pin[1] = 16'h00FF;
        sin[1] = 4'h0;
        lv[1]  = 1'b1;
        sft[1] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check_eq($sformatf("hs_busy%0d", k), 32'(busy_w[1]), 32'((k % 6) < 4));
            check_eq($sformatf("hs_done%0d", k), 32'(done_w[1]), 32'((k % 6) == 4));
            check_eq($sformatf("hs_ready%0d", k), 32'(ready_w[1]), 32'((k % 6) == 5));
        end
        lv[1]  = 1'b0;
        sft[1] = 1'b0;
        check_eq("hs_pout", 32'(get_pout(1)), 32'd0);

        // Abort together with sft_en on the fifth beat of sixteen.
        @(negedge clk);
        pin[0] = 16'hA5C3;
        lv[0]  = 1'b1;
        @(negedge clk);
        lv[0]  = 1'b0;
        sin[0] = 4'h0;
        sft[0] = 1'b1;
        repeat (4) @(negedge clk);
        ab[0] = 1'b1;
        @(negedge clk);
        ab[0]  = 1'b0;
        sft[0] = 1'b0;
        check_eq("abort_busy", 32'(busy_w[0]), 32'd0);
        check_eq("abort_ready", 32'(ready_w[0]), 32'd1);
        check_eq("abort_done", 32'(done_w[0]), 32'd0);
        check_eq("abort_pout", 32'(get_pout(0)), 32'h1234);
        // Four shifts of 0xA5C3 leave bit 11 (0) at the top; a fifth would expose bit 10 (1).
        check_eq("abort_sout", 32'(get_sout(0)), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check_eq("abort_no_done", 32'(done_w[0]), 32'd0);
        end

        // Asynchronous reset between edges after seven beats.
        @(negedge clk);
        pin[0] = 16'hFFFF;
        lv[0]  = 1'b1;
        @(negedge clk);
        lv[0]  = 1'b0;
        sin[0] = 4'h1;
        sft[0] = 1'b1;
        repeat (7) @(negedge clk);
        sft[0] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_sout", 32'(get_sout(0)), 32'd0);
        check_eq("arst_pout", 32'(get_pout(0)), 32'd0);
        check_eq("arst_done", 32'(done_w[0]), 32'd0);
        check_eq("arst_busy", 32'(busy_w[0]), 32'd0);
        check_eq("arst_ready", 32'(ready_w[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_xfer(0, tx_word, 16, sin_bits, sout_bits, 16'h1234, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
